// File: rtl/rgb_led_pkg.sv
// Shared types and helpers for the RGB LED PWM driver.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        MODE_STEADY = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_FADE   = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    // Largest duty value for a given PWM width; also the PWM period in clocks.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Pin level for a logical on/off state, honouring pull-up (active-low) wiring.
    function automatic logic led_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/rgb_led_pwm_array_env.sv
// Free-running blink phase and fade triangle envelope, shared by every channel.
module rgb_led_env
    import rgb_led_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int BLINK_PERIOD = 27_000_000
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                restart,
    output logic [PWM_BITS-1:0] env,
    output logic                blink_on
);

    localparam int W     = PWM_BITS;
    localparam int MAX   = pwm_max(W);
    localparam int STEP  = BLINK_PERIOD / (2 * MAX);
    localparam int PH_W  = $clog2(BLINK_PERIOD);
    localparam int PRE_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [PH_W-1:0]  phase_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [W-1:0]     env_reg;
    logic             dir_up_reg;

    // Phase wraps at BLINK_PERIOD regardless of mode.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            phase_reg <= '0;
        else if (phase_reg == PH_W'(BLINK_PERIOD - 1))
            phase_reg <= '0;
        else
            phase_reg <= phase_reg + PH_W'(1);
    end

    assign blink_on = (phase_reg < PH_W'(BLINK_PERIOD / 2));

    // Triangle envelope: one step per STEP clocks, turning at 0 and MAX so it never wraps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_reg    <= '0;
            env_reg    <= '0;
            dir_up_reg <= 1'b1;
        end else if (restart) begin
            pre_reg    <= '0;
            env_reg    <= '0;
            dir_up_reg <= 1'b1;
        end else if (pre_reg == PRE_W'(STEP - 1)) begin
            pre_reg <= '0;
            if (dir_up_reg) begin
                if (env_reg == MAX_V) begin
                    env_reg    <= env_reg - W'(1);
                    dir_up_reg <= 1'b0;
                end else begin
                    env_reg <= env_reg + W'(1);
                end
            end else begin
                if (env_reg == '0) begin
                    env_reg    <= env_reg + W'(1);
                    dir_up_reg <= 1'b1;
                end else begin
                    env_reg <= env_reg - W'(1);
                end
            end
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    assign env = env_reg;

endmodule

// File: rtl/rgb_led_pwm_array.sv
// Multi-LED RGB PWM driver with STEADY / BLINK / FADE / OFF modes.
// Duties are double-buffered and take effect only at PWM period boundaries.
// Optional build macro RGB_LED_GAMMA_EN: square-law gamma on the shadow->active path.
module rgb_led_pwm_array
    import rgb_led_pkg::*;
#(
    parameter int NUM_LEDS     = 1,
    parameter int PWM_BITS     = 8,
    parameter int BLINK_PERIOD = 27_000_000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [1:0]                     mode,
    input  logic                           load,
    input  logic [NUM_LEDS*3*PWM_BITS-1:0] rgb,
    output logic [NUM_LEDS-1:0]            led_r,
    output logic [NUM_LEDS-1:0]            led_g,
    output logic [NUM_LEDS-1:0]            led_b,
    output logic                           sync
);

    localparam int W   = PWM_BITS;
    localparam int MAX = pwm_max(W);
    localparam int NCH = NUM_LEDS * 3;
    localparam logic [W-1:0] LAST    = W'(MAX - 1);
    localparam logic [W-1:0] MAX_V   = W'(MAX);
    localparam logic         LED_OFF = led_level(1'b0, ACTIVE_LOW != 0);

    logic [W-1:0] cycle_reg;
    mode_t        mode_reg;
    mode_t        mode_in;
    logic         boundary;
    logic         fade_restart;
    logic [W-1:0] env_val;
    logic [W:0]   env_p1;
    logic         blink_on;
    logic [NCH-1:0] out_vec;

    assign mode_in      = mode_t'(mode);
    assign boundary     = (cycle_reg == LAST);
    assign sync         = boundary;
    assign fade_restart = boundary && (mode_in == MODE_FADE) && (mode_reg != MODE_FADE);
    assign env_p1       = {1'b0, env_val} + (W+1)'(1);

    // PWM cycle counter, 0..MAX-1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cycle_reg <= '0;
        else if (boundary)
            cycle_reg <= '0;
        else
            cycle_reg <= cycle_reg + W'(1);
    end

    // Mode is only sampled at a period boundary so a period is never split.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            mode_reg <= MODE_OFF;
        else if (boundary)
            mode_reg <= mode_in;
    end

    rgb_led_env #(
        .PWM_BITS     (PWM_BITS),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_env (
        .clk      (clk),
        .n_rst    (n_rst),
        .restart  (fade_restart),
        .env      (env_val),
        .blink_on (blink_on)
    );

    // Channel index gi = led*3 + {0:B, 1:G, 2:R}, matching the rgb bus packing.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] shadow_reg;
            logic [W-1:0] active_reg;
            logic [W-1:0] src;
            logic [W-1:0] shaped;
            logic [W-1:0] eff;
            logic         out_reg;

            // A load on the boundary cycle bypasses the shadow so it lands next period.
            assign src = load ? rgb[gi*W +: W] : shadow_reg;

`ifdef RGB_LED_GAMMA_EN
            assign shaped = (src == MAX_V) ? MAX_V : W'(((2*W)'(src) * (2*W)'(src)) >> W);
`else
            assign shaped = src;
`endif

            // Shadow captures every load; active follows it only at boundaries.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (load)
                        shadow_reg <= rgb[gi*W +: W];
                    if (boundary)
                        active_reg <= shaped;
                end
            end

            // Effective duty after mode shaping.
            always_comb begin
                eff = '0;
                case (mode_reg)
                    MODE_STEADY: eff = active_reg;
                    MODE_BLINK:  eff = blink_on ? active_reg : '0;
                    MODE_FADE:   eff = W'(((2*W)'(active_reg) * (2*W)'(env_p1)) >> W);
                    default:     eff = '0;
                endcase
            end

            // Registered compare drives the pin.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst)
                    out_reg <= LED_OFF;
                else
                    out_reg <= led_level(cycle_reg < eff, ACTIVE_LOW != 0);
            end

            assign out_vec[gi] = out_reg;
        end

        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            assign led_b[gi] = out_vec[gi*3];
            assign led_g[gi] = out_vec[gi*3 + 1];
            assign led_r[gi] = out_vec[gi*3 + 2];
        end
    endgenerate

endmodule

// File: tb/tb_rgb_led_pwm_array.sv
// Self-checking bench for rgb_led_pwm_array (NUM_LEDS=2, PWM_BITS=4, BLINK_PERIOD=120).
module tb_rgb_led_pwm_array;

    localparam int NL   = 2;
    localparam int W    = 4;
    localparam int MAX  = 15;
    localparam int BP   = 120;
    localparam int STEP = BP / (2 * MAX);
    localparam int NCH  = NL * 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic              load;
    logic [NCH*W-1:0]  rgb;
    logic [NL-1:0]     led_r, led_g, led_b;
    logic              sync;
    logic [NCH-1:0]    dut_led;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (edges since reset release, latched mode, duties).
    int             n = 0;
    int             fade_n = 0;
    int             m_mode = 3;
    int             shadow [NCH];
    int             active [NCH];
    logic [NCH-1:0] exp_led = '1;
    logic           exp_sync = 1'b0;

    rgb_led_pwm_array #(
        .NUM_LEDS     (NL),
        .PWM_BITS     (W),
        .BLINK_PERIOD (BP),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk   (clk),
        .n_rst (rst_n),
        .mode  (mode),
        .load  (load),
        .rgb   (rgb),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b),
        .sync  (sync)
    );

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_map
            assign dut_led[gi*3]     = led_b[gi];
            assign dut_led[gi*3 + 1] = led_g[gi];
            assign dut_led[gi*3 + 2] = led_r[gi];
        end
    endgenerate

    function automatic int tri_env(input int k);
        int r;
        r = k % (2 * MAX);
        return (r <= MAX) ? r : 2 * MAX - r;
    endfunction

    function automatic int gam(input int x);
`ifdef RGB_LED_GAMMA_EN
        return (x == MAX) ? MAX : (x * x) >> W;
`else
        return x;
`endif
    endfunction

    function automatic int duty_of(input logic [NCH*W-1:0] v, input int ch);
        return int'(v[ch*W +: W]);
    endfunction

    function automatic int eff_of(input int duty, input int md, input int nn, input int fn);
        case (md)
            0: return duty;
            1: return ((nn % BP) < BP / 2) ? duty : 0;
            2: return (duty * (tri_env((nn - fn) / STEP) + 1)) >> W;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: expected pin levels after each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= 0;
            fade_n   <= 0;
            m_mode   <= 3;
            exp_led  <= '1;
            exp_sync <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                shadow[ch] <= 0;
                active[ch] <= 0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                exp_led[ch] <= ((n % MAX) < eff_of(active[ch], m_mode, n, fade_n)) ? 1'b0 : 1'b1;
                if (load)
                    shadow[ch] <= duty_of(rgb, ch);
                if ((n % MAX) == MAX - 1)
                    active[ch] <= gam(load ? duty_of(rgb, ch) : shadow[ch]);
            end
            if ((n % MAX) == MAX - 1) begin
                if (int'(mode) == 2 && m_mode != 2)
                    fade_n <= n + 1;
                m_mode <= int'(mode);
            end
            n        <= n + 1;
            exp_sync <= (((n + 1) % MAX) == MAX - 1);
        end
    end

    task automatic set_ch(input int led, input int c, input int val);
        rgb[(led*3 + c)*W +: W] = W'(val);
    endtask

    // Returns at the negedge where sync is high (last cycle of a period).
    task automatic wait_sync(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sync === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at a sync negedge: skips the boundary edge, then counts on-clocks of one period.
    task automatic measure(input int ch, output int on_cnt);
        on_cnt = 0;
        @(negedge clk);
        for (int j = 0; j < MAX; j++) begin
            @(negedge clk);
            if (dut_led[ch] === 1'b0) on_cnt++;
        end
    endtask

    task automatic test_reset;
        int first;
        #10;
        n_cmp++;
        if ({dut_led, sync} !== {{NCH{1'b1}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", {dut_led, sync}, {{NCH{1'b1}}, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 2'd0;
        rgb = NCH*W'($urandom);
        set_ch(0, 2, 15);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (24) begin
            @(negedge clk);
            n_cmp++;
            if ({dut_led, sync} !== {exp_led, exp_sync}) begin
                n_fail++;
                $display("FAIL reset_prerun: got %b required %b", {dut_led, sync}, {exp_led, exp_sync});
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dut_led, sync} !== {{NCH{1'b1}}, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %b required %b", {dut_led, sync}, {{NCH{1'b1}}, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (sync === 1'b1) begin
                first = i;
                break;
            end
        end
        // cycle==14 is reached after 14 edges: the 15th clock cycle after release.
        n_cmp++;
        if (first != 14) begin
            n_fail++;
            $display("FAIL first_sync: edge %0d required 14", first);
        end
        $display("test_reset done");
    endtask

    task automatic test_steady;
        bit ok;
        int on_r, on_g, on_b;
        mode = 2'd0;
        @(negedge clk);
        rgb = NCH*W'($urandom);
        set_ch(0, 2, 5);
        set_ch(0, 1, 0);
        set_ch(0, 0, 15);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_sync(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL steady_sync: no sync within 40 clks"); end
        repeat (40) begin
            @(negedge clk);
            n_cmp++;
            if ({dut_led, sync} !== {exp_led, exp_sync}) begin
                n_fail++;
                $display("FAIL steady_model: got %b required %b", {dut_led, sync}, {exp_led, exp_sync});
            end
        end
        wait_sync(ok);
        fork
            measure(2, on_r);
            measure(1, on_g);
            measure(0, on_b);
        join
        n_cmp++;
        if (on_r != 5) begin n_fail++; $display("FAIL steady_r5: on %0d required 5", on_r); end
        n_cmp++;
        if (on_g != 0) begin n_fail++; $display("FAIL steady_duty0: on %0d required 0", on_g); end
        n_cmp++;
        if (on_b != 15) begin n_fail++; $display("FAIL steady_duty15: on %0d required 15", on_b); end
        $display("test_steady done: on r=%0d g=%0d b=%0d", on_r, on_g, on_b);
    endtask

    task automatic test_load_timing;
        bit ok;
        int cnt_a, cnt_b, cnt_c;
        wait_sync(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL load_sync: no sync within 40 clks"); end
        @(negedge clk);
        cnt_a = 0;
        cnt_b = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j <= 15 && dut_led[2] === 1'b0) cnt_a++;
            if (j > 15 && dut_led[2] === 1'b0) cnt_b++;
            if (j == 7) begin
                set_ch(0, 2, 12);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        n_cmp++;
        if (cnt_a != 5) begin n_fail++; $display("FAIL load_midperiod_old: on %0d required 5", cnt_a); end
        n_cmp++;
        if (cnt_b != 12) begin n_fail++; $display("FAIL load_midperiod_new: on %0d required 12", cnt_b); end
        wait_sync(ok);
        set_ch(0, 2, 3);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cnt_c = 0;
        for (int j = 0; j < MAX; j++) begin
            @(negedge clk);
            if (dut_led[2] === 1'b0) cnt_c++;
        end
        n_cmp++;
        if (cnt_c != 3) begin n_fail++; $display("FAIL load_on_boundary: on %0d required 3", cnt_c); end
        $display("test_load_timing done: %0d %0d %0d", cnt_a, cnt_b, cnt_c);
    endtask

    task automatic test_blink;
        set_ch(0, 2, 15);
        load = 1'b1;
        mode = 2'd1;
        @(negedge clk);
        load = 1'b0;
        repeat (360) begin
            @(negedge clk);
            n_cmp++;
            if ({dut_led, sync} !== {exp_led, exp_sync}) begin
                n_fail++;
                $display("FAIL blink_model: n=%0d got %b required %b", n, {dut_led, sync}, {exp_led, exp_sync});
            end
        end
        $display("test_blink done");
    endtask

    task automatic test_fade;
        mode = 2'd3;
        repeat (20) @(negedge clk);
        set_ch(0, 2, 15);
        load = 1'b1;
        mode = 2'd2;
        @(negedge clk);
        load = 1'b0;
        repeat (400) begin
            @(negedge clk);
            n_cmp++;
            if ({dut_led, sync} !== {exp_led, exp_sync}) begin
                n_fail++;
                $display("FAIL fade_model: n=%0d got %b required %b", n, {dut_led, sync}, {exp_led, exp_sync});
            end
        end
        $display("test_fade done");
    endtask

    task automatic test_gamma;
        bit ok;
        int on_r, on_g, req_r;
`ifdef RGB_LED_GAMMA_EN
        req_r = 4;
`else
        req_r = 8;
`endif
        mode = 2'd0;
        set_ch(0, 2, 8);
        set_ch(0, 1, 15);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_sync(ok);
        wait_sync(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL gamma_sync: no sync within 40 clks"); end
        fork
            measure(2, on_r);
            measure(1, on_g);
        join
        n_cmp++;
        if (on_r != req_r) begin n_fail++; $display("FAIL gamma_duty8: on %0d required %0d", on_r, req_r); end
        n_cmp++;
        if (on_g != 15) begin n_fail++; $display("FAIL gamma_duty15: on %0d required 15", on_g); end
        $display("test_gamma done: r=%0d g=%0d", on_r, on_g);
    endtask

    task automatic test_random;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dut_led, sync} !== {exp_led, exp_sync}) begin
                n_fail++;
                $display("FAIL random_model: n=%0d got %b required %b", n, {dut_led, sync}, {exp_led, exp_sync});
            end
            load = ($urandom_range(0, 7) == 0);
            if (load) rgb = NCH*W'($urandom);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
        end
        load = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b1;
        mode  = 2'd3;
        load  = 1'b0;
        rgb   = '0;
        #2 rst_n = 1'b0;
        test_reset();
        test_steady();
        test_load_timing();
        test_blink();
        test_fade();
        test_gamma();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
